// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_INC           = 32'd4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    WAIT  = 1'b0,
    READY = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_ctr.sv
// Loadable down-counter that times the instruction-memory settle window.
module fetch_wait_ctr #(
  parameter int          W    = 2,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         hold,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= INIT;
    end else if (load) begin
      cnt <= value;
    end else if (!hold && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, waits out the async memory, fills the IF/ID register.
// Optional FETCH_PERF_EN adds fetch_count / flush_count outputs.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int                MEM_WAIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        flush_count
`endif
);

  localparam int          CTR_W    = (MEM_WAIT_CYCLES > 1) ? $clog2(MEM_WAIT_CYCLES) : 1;
  localparam logic [CTR_W-1:0] CTR_FULL = CTR_W'(MEM_WAIT_CYCLES - 1);

  logic [ADDR_W-1:0] pc;
  fetch_state_e      state;
  logic              ctr_zero;
  logic              slot_free;
  logic              capture;
  logic              ctr_load;
  logic              ctr_hold;

  // The counter sits at zero in READY, so ctr_zero alone marks a capture as due.
  assign slot_free = !id_valid || id_ready;
  assign capture   = ctr_zero && slot_free && !redirect_valid;
  assign ctr_load  = redirect_valid || capture;
  assign ctr_hold  = (state == READY);
  assign imem_addr = pc;

  fetch_wait_ctr #(
    .W    (CTR_W),
    .INIT (CTR_FULL)
  ) u_wait_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ctr_load),
    .hold  (ctr_hold),
    .value (CTR_FULL),
    .zero  (ctr_zero)
  );

  // NOTE: the IF/ID data registers are reset too, so decode never observes X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= WAIT;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ~ADDR_W'(3);
      state    <= WAIT;
      id_valid <= 1'b0;
    end else if (capture) begin
      id_instr    <= imem_instr;
      id_pc       <= pc;
      id_pc_plus4 <= pc + PC_INC;
      id_valid    <= 1'b1;
      pc          <= pc + PC_INC;
      state       <= WAIT;
    end else begin
      if (state == WAIT && ctr_zero) begin
        state <= READY;
      end
      if (id_valid && id_ready) begin
        id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // A wait is "in progress" once at least one cycle has elapsed since the last (re)load.
  logic wait_fresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      flush_count <= '0;
      wait_fresh  <= 1'b1;
    end else begin
      wait_fresh <= ctr_load;
      if (capture) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (redirect_valid && (id_valid || state == READY || !wait_fresh)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized ready/redirect traffic.
module tb_fetch_unit;

  localparam int MWC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus4;

  logic [31:0] imem_addr2, imem_instr2;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0;
  logic        id_ready2 = 1'b1;
  logic        id_valid2;
  logic [31:0] id_instr2, id_pc2, id_pc_plus42;

  int checks = 0;
  int errors = 0;

  // Reference model: address age in cycles plus the contents of the decode slot.
  logic [31:0] m_pc;
  int          m_age;
  logic        m_valid;
  logic [31:0] m_instr, m_idpc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'hA000_0000 + (addr >> 2);
  endfunction

  assign imem_instr  = mem_word(imem_addr);
  assign imem_instr2 = mem_word(imem_addr2);

  fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_WAIT_CYCLES(MWC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .MEM_WAIT_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .id_ready(id_ready2),
    .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2), .id_pc_plus4(id_pc_plus42)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_age   = 0;
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_idpc  = 32'h0;
  endtask

  task automatic model_edge(input logic rdy, input logic rv, input logic [31:0] rpc);
    if (rv) begin
      m_pc    = rpc & 32'hFFFF_FFFC;
      m_age   = 0;
      m_valid = 1'b0;
    end else begin
      m_age++;
      if (m_age >= MWC && (!m_valid || rdy)) begin
        m_valid = 1'b1;
        m_instr = mem_word(m_pc);
        m_idpc  = m_pc;
        m_pc    = m_pc + 32'd4;
        m_age   = 0;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("imem_addr", imem_addr, m_pc);
    check("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
    if (m_valid) begin
      check("id_instr", id_instr, m_instr);
      check("id_pc", id_pc, m_idpc);
      check("id_pc_plus4", id_pc_plus4, m_idpc + 32'd4);
    end
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    model_edge(rdy, rv, rpc);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_pc", id_pc, 32'h0);
    check("rst_pc_plus4", id_pc_plus4, 32'h0);
    check("rst_addr2", imem_addr2, 32'hFFFF_FFF8);
    check("rst_valid2", {31'h0, id_valid2}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1;

    // Reset release and first fetches; dut2 exercises the PC wrap at one cycle per fetch.
    do_reset();
    cycle(1'b1, 1'b0, 32'h0);
    check("wrap_pc0", id_pc2, 32'hFFFF_FFF8);
    cycle(1'b1, 1'b0, 32'h0);
    check("wrap_pc1", id_pc2, 32'hFFFF_FFFC);
    check("wrap_plus4", id_pc_plus42, 32'h0000_0000);
    cycle(1'b1, 1'b0, 32'h0);
    check("wrap_pc2", id_pc2, 32'h0000_0000);
    check("wrap_valid", {31'h0, id_valid2}, 32'h1);
    check("edge3_novalid", {31'h0, id_valid}, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check("edge4_instr", id_instr, 32'hA000_0000);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);
    check("edge8_instr", id_instr, 32'hA000_0001);
    check("edge8_pc", id_pc, 32'h4);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);
    check("edge12_instr", id_instr, 32'hA000_0002);
    check("edge12_pc", id_pc, 32'h8);

    // Back-pressure: hold for 10 cycles, then the pending capture lands immediately.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0);
    check("hold_instr", id_instr, 32'hA000_0000);
    check("hold_addr", imem_addr, 32'h4);
    cycle(1'b1, 1'b0, 32'h0);
    check("release_instr", id_instr, 32'hA000_0001);
    check("release_valid", {31'h0, id_valid}, 32'h1);

    // Redirect flushes a valid entry even without id_ready.
    cycle(1'b0, 1'b1, 32'h0000_0103);
    check("redir_valid", {31'h0, id_valid}, 32'h0);
    check("redir_addr", imem_addr, 32'h100);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);
    check("redir_instr", id_instr, 32'hA000_0040);
    check("redir_pc", id_pc, 32'h100);

    // Redirect coinciding with a due capture discards it.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    check("coll_valid", {31'h0, id_valid}, 32'h0);
    check("coll_addr", imem_addr, 32'h200);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    check("coll_wait", {31'h0, id_valid}, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    check("coll_pc", id_pc, 32'h200);
    check("coll_instr", id_instr, 32'hA000_0080);

    // Randomized ready and redirect traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), $urandom);
    end
    cycle(1'b1, 1'b0, 32'h0);

    // Reset mid-wait, then mid-READY.
    do_reset();
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0);
    check("pre_rst_valid", {31'h0, id_valid}, 32'h1);
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the asynchronous instruction memory.
- Owns the program counter and drives the word-aligned byte address to the memory.
- Waits a fixed number of cycles for the slow memory output to settle, then captures the instruction into an IF/ID output register.
- Presents the captured instruction to decode over a valid/ready handshake; supports branch/jump redirect with flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
MEM_WAIT_CYCLES, 4, cycles from address change to instruction capture; >=1; MEM_WAIT_CYCLES*Tclk must exceed memory access delay.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
imem_addr  output  32  byte address to instruction memory; equals pc register
imem_instr  input  32  instruction word returned by memory
redirect_valid  input  1  load redirect_pc and flush this cycle
redirect_pc  input  32  new PC; bits [1:0] are ignored and forced to 0
id_ready  input  1  decode accepts id_* this cycle
id_valid  output  1  id_instr/id_pc hold a valid fetched instruction
id_instr  output  32  captured instruction
id_pc  output  32  address the instruction was fetched from
id_pc_plus4  output  32  id_pc+4, modulo 2^32

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, wait_ctr=MEM_WAIT_CYCLES-1, state=WAIT, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0.
- imem_addr is driven combinationally from the pc register; it is stable except on a pc update.
- WAIT state:
  - wait_ctr decrements each cycle.
  - At wait_ctr==0, the block attempts capture.
- Capture happens only when the slot is free, i.e. !id_valid || id_ready. On capture:
  - id_instr<=imem_instr, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1.
  - pc<=pc+4, wrapping 32'hFFFF_FFFC -> 0.
  - wait_ctr<=MEM_WAIT_CYCLES-1; stay in WAIT.
- If wait_ctr==0 but the slot is not free, go to READY and hold pc and wait_ctr. READY captures on the first cycle the slot frees, then returns to WAIT.
- Latency and throughput: the first id_valid rises after clock edge MEM_WAIT_CYCLES following reset release. Steady-state throughput is one instruction per MEM_WAIT_CYCLES cycles (1/cycle when the parameter is 1).
- Handshake:
  - id_* is held stable while id_valid && !id_ready.
  - On id_valid && id_ready with no capture in the same cycle, id_valid<=0.
  - A consume and a capture in the same cycle give back-to-back valid with the new data.
- Redirect, highest priority in any state:
  - pc<={redirect_pc[31:2],2'b00}, id_valid<=0 (flush, regardless of id_ready), wait_ctr<=MEM_WAIT_CYCLES-1, state=WAIT.
  - A capture due in the same cycle is discarded.
- Back-to-back redirects: the last one wins. Each redirect restarts the full wait.
- Reset asserted mid-wait or mid-hold returns all state to reset values immediately; no partial instruction is emitted.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs fetch_count[31:0] and flush_count[31:0], both reset to 0.
  - fetch_count increments on each capture.
  - flush_count increments on each redirect that discards a valid id_* or an in-progress wait.
  - Both counters wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds: INSTR_W=32, ADDR_W=32, PC_INC=32'd4, the fetch state enum (WAIT, READY), and the DEFAULT_RESET_PC constant.
- One natural sub-module: fetch_wait_ctr. It is a loadable down-counter with inputs load, hold, and value, and an output zero. The top level keeps pc, the FSM and the IF/ID register.

Test Plan:
- Reset release with MEM_WAIT_CYCLES=4, bench memory word i = 32'hA000_0000+i, id_ready=1 -> id_valid pulses at edges 4, 8, 12 with id_instr A000_0000, A000_0001, A000_0002 and id_pc 0, 4, 8.
- id_ready=0 for 10 cycles after the first capture -> id_* held at A000_0000/pc 0 and imem_addr held at 4. When id_ready returns to 1, the next capture (A000_0001) lands the next cycle.
- Redirect with redirect_pc=32'h0000_0103 while id_valid=1 -> id_valid=0 next cycle, imem_addr=32'h100. The next id_instr is word 0x40 after 4 cycles, with id_pc=0x100.
- Redirect asserted in the same cycle as a due capture -> no id_valid for the old pc; the new pc is fetched after a full wait.
- RESET_PC=32'hFFFF_FFF8, MEM_WAIT_CYCLES=1, id_ready=1 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, with id_pc_plus4=0 on the FFFF_FFFC fetch.
- rst_n pulsed low mid-wait and mid-READY -> all outputs 0 immediately, imem_addr=RESET_PC. With FETCH_PERF_EN, fetch_count=0.
